axi4lite_slave_regs: RTL and testbench

AXI4-Lite slave (responder) that exposes a bank of 32-bit control/status registers to the AXI4-Lite master driven by the PicoRV32 core. It is the target the CPU uses to configure the NPU: software-visible registers drive flat outputs, a self-clearing START bit pulses the datapath, and a read-only STATUS word samples hardware state. It supports one outstanding write and one outstanding read, and AW and W may arrive in either order.

---
 rtl/axi4lite_slave_regs.sv | 182 ++++++++++++++++++
 tb/tb_axi4lite_slave_regs.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite register bank: CTRL (self-clearing START), read-only STATUS, plain R/W words.
// Ports: AXI4-Lite slave (AW/W/B/AR/R), reg_out flat contents, wr_pulse, start_pulse, hw_status.
module axi4lite_slave_regs #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic [2:0]                     s_axi_awprot,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic [2:0]                     s_axi_arprot,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            wr_pulse,
  output logic                           start_pulse,
  input  logic [DATA_WIDTH-1:0]          hw_status
);

  localparam int IW = $clog2(NUM_REGS);
  localparam int SW = DATA_WIDTH / 8;
  localparam int HW = ADDR_WIDTH - 2;
  localparam logic [IW-1:0] CTRL_IDX = '0;
  localparam logic [IW-1:0] STAT_IDX = IW'(1);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic                  aw_held_q, aw_held_d;
  logic [HW-1:0]         aw_addr_q, aw_addr_d;
  logic                  w_held_q, w_held_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [SW-1:0]         w_strb_q, w_strb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
  logic                  start_q, start_d;

  logic          aw_hs, w_hs, ar_hs, commit;
  logic [IW-1:0] w_idx, r_idx;
  logic          w_oor, r_oor, w_hit;
  logic          unused_ok;

  assign s_axi_awready = !aw_held_q;
  assign s_axi_wready  = !w_held_q;
  assign s_axi_arready = !rvalid_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign reg_out       = regs_q;
  assign wr_pulse      = wr_pulse_q;
  assign start_pulse   = start_q;

  assign aw_hs  = s_axi_awvalid && !aw_held_q;
  assign w_hs   = s_axi_wvalid && !w_held_q;
  assign ar_hs  = s_axi_arvalid && !rvalid_q;
  assign commit = aw_held_q && w_held_q && !bvalid_q;

  // Held address is stored as a word address; upper bits flag out-of-range.
  assign w_idx = aw_addr_q[IW-1:0];
  assign w_oor = |aw_addr_q[HW-1:IW];
  assign w_hit = commit && !w_oor && (w_idx != STAT_IDX);
  assign r_idx = s_axi_araddr[IW+1:2];
  assign r_oor = |s_axi_araddr[ADDR_WIDTH-1:IW+2];

  assign unused_ok = ^{s_axi_awprot, s_axi_arprot,
                       s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  always_comb begin
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end
    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_addr_d = s_axi_awaddr[ADDR_WIDTH-1:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = s_axi_wdata;
      w_strb_d = s_axi_wstrb;
    end
  end

  always_comb begin
    regs_d     = regs_q;
    wr_pulse_d = '0;
    start_d    = 1'b0;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    if (s_axi_bready) bvalid_d = 1'b0;
    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = w_oor ? SLVERR : OKAY;
    end
    if (w_hit) begin
      for (int b = 0; b < SW; b++) begin
        if (w_strb_q[b]) regs_d[w_idx][8*b +: 8] = w_data_q[8*b +: 8];
      end
      wr_pulse_d[w_idx] = 1'b1;
      start_d = (w_idx == CTRL_IDX) && w_strb_q[0] && w_data_q[0];
    end
    // START is never stored, so CTRL bit 0 always reads back 0.
    regs_d[CTRL_IDX][0] = 1'b0;
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (s_axi_rready) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = OKAY;
      rdata_d  = regs_q[r_idx];
      if (r_oor) begin
        rdata_d = '0;
        rresp_d = SLVERR;
      end else if (r_idx == STAT_IDX) begin
        rdata_d = hw_status;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held_q  <= 1'b0;
      aw_addr_q  <= '0;
      w_held_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= OKAY;
      rvalid_q   <= 1'b0;
      rresp_q    <= OKAY;
      rdata_q    <= '0;
      regs_q     <= '0;
      wr_pulse_q <= '0;
      start_q    <= 1'b0;
    end else begin
      aw_held_q  <= aw_held_d;
      aw_addr_q  <= aw_addr_d;
      w_held_q   <= w_held_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
      start_q    <= start_d;
    end
  end

endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// Bench for axi4lite_slave_regs: directed scenarios plus random AXI traffic
// compared every cycle against a transaction-level model of the register bank.
module tb_axi4lite_slave_regs;

  localparam int NR = 16;
  localparam int RW = NR * 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   s_axi_awaddr;
  logic [2:0]    s_axi_awprot;
  logic          s_axi_awvalid;
  logic          s_axi_awready;
  logic [31:0]   s_axi_wdata;
  logic [3:0]    s_axi_wstrb;
  logic          s_axi_wvalid;
  logic          s_axi_wready;
  logic [1:0]    s_axi_bresp;
  logic          s_axi_bvalid;
  logic          s_axi_bready;
  logic [31:0]   s_axi_araddr;
  logic [2:0]    s_axi_arprot;
  logic          s_axi_arvalid;
  logic          s_axi_arready;
  logic [31:0]   s_axi_rdata;
  logic [1:0]    s_axi_rresp;
  logic          s_axi_rvalid;
  logic          s_axi_rready;
  logic [RW-1:0] reg_out;
  logic [NR-1:0] wr_pulse;
  logic          start_pulse;
  logic [31:0]   hw_status;

  always #5 clk = ~clk;

  axi4lite_slave_regs #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .NUM_REGS(NR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_axi_awaddr(s_axi_awaddr),
    .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr),
    .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .reg_out(reg_out),
    .wr_pulse(wr_pulse),
    .start_pulse(start_pulse),
    .hw_status(hw_status)
  );

  int checks = 0;
  int errors = 0;

  // Model state: register array, pending requests and outstanding responses.
  logic [31:0]   m_regs [NR];
  bit            m_aw, m_w, m_b, m_r;
  logic [31:0]   m_awaddr, m_wdata;
  logic [3:0]    m_wstrb;
  logic [1:0]    m_bresp, m_rresp;
  logic [31:0]   m_rdata;
  logic [NR-1:0] m_pulse;
  bit            m_start;
  bit            acc_aw, acc_w, acc_ar;

  task automatic chk(input string name, input logic [RW-1:0] got,
                     input logic [RW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_aw = 0; m_w = 0; m_b = 0; m_r = 0;
    m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0;
    m_pulse = '0; m_start = 0;
    acc_aw = 0; acc_w = 0; acc_ar = 0;
  endtask

  // One clock edge of the slave, evaluated from the inputs present at the edge.
  task automatic model_step();
    bit          commit;
    int unsigned idx;
    logic [31:0] mask;
    if (!rst_n) begin
      model_reset();
      return;
    end
    acc_aw = s_axi_awvalid && !m_aw;
    acc_w  = s_axi_wvalid && !m_w;
    acc_ar = s_axi_arvalid && !m_r;
    commit = m_aw && m_w && !m_b;
    if (m_r && s_axi_rready) m_r = 0;
    else if (acc_ar) begin
      m_r = 1;
      idx = s_axi_araddr >> 2;
      if (idx >= NR) begin
        m_rdata = 0;
        m_rresp = 2'b10;
      end else begin
        m_rresp = 2'b00;
        m_rdata = (idx == 1) ? hw_status : m_regs[idx];
      end
    end
    m_pulse = '0;
    m_start = 0;
    if (m_b && s_axi_bready) m_b = 0;
    else if (commit) begin
      m_b = 1;
      idx = m_awaddr >> 2;
      if (idx >= NR) m_bresp = 2'b10;
      else begin
        m_bresp = 2'b00;
        if (idx != 1) begin
          mask = 0;
          for (int b = 0; b < 4; b++)
            if (m_wstrb[b]) mask = mask | (32'hFF << (8 * b));
          m_regs[idx] = (m_regs[idx] & ~mask) | (m_wdata & mask);
          if (idx == 0) begin
            m_start = m_wstrb[0] && m_wdata[0];
            m_regs[0][0] = 1'b0;
          end
          m_pulse[idx] = 1'b1;
        end
      end
    end
    if (commit) begin
      m_aw = 0;
      m_w = 0;
    end
    if (acc_aw) begin
      m_aw = 1;
      m_awaddr = s_axi_awaddr;
    end
    if (acc_w) begin
      m_w = 1;
      m_wdata = s_axi_wdata;
      m_wstrb = s_axi_wstrb;
    end
  endtask

  task automatic compare();
    logic [RW-1:0] flat;
    for (int i = 0; i < NR; i++) flat[32*i +: 32] = m_regs[i];
    chk("awready", RW'(s_axi_awready), RW'(!m_aw));
    chk("wready", RW'(s_axi_wready), RW'(!m_w));
    chk("arready", RW'(s_axi_arready), RW'(!m_r));
    chk("bvalid", RW'(s_axi_bvalid), RW'(m_b));
    chk("rvalid", RW'(s_axi_rvalid), RW'(m_r));
    if (m_b) chk("bresp", RW'(s_axi_bresp), RW'(m_bresp));
    if (m_r) begin
      chk("rdata", RW'(s_axi_rdata), RW'(m_rdata));
      chk("rresp", RW'(s_axi_rresp), RW'(m_rresp));
    end
    chk("reg_out", reg_out, flat);
    chk("wr_pulse", RW'(wr_pulse), RW'(m_pulse));
    chk("start_pulse", RW'(start_pulse), RW'(m_start));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [1:0] resp,
                          output logic [NR-1:0] pulse, output logic start);
    s_axi_awaddr = a; s_axi_awvalid = 1;
    s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1;
    s_axi_bready = 1;
    cycle();
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    chk("wr_no_early_b", RW'(s_axi_bvalid), RW'(0));
    cycle();
    chk("wr_bvalid", RW'(s_axi_bvalid), RW'(1));
    resp = s_axi_bresp;
    pulse = wr_pulse;
    start = start_pulse;
    cycle();
    s_axi_bready = 0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                         output logic [1:0] resp);
    s_axi_araddr = a; s_axi_arvalid = 1; s_axi_rready = 0;
    cycle();
    s_axi_arvalid = 0;
    chk("rd_rvalid", RW'(s_axi_rvalid), RW'(1));
    d = s_axi_rdata;
    resp = s_axi_rresp;
    cycle();
    s_axi_rready = 1;
    cycle();
    s_axi_rready = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = ($urandom_range(0, 17) << 2) | $urandom_range(0, 3);
    if ($urandom_range(0, 15) == 0) a = a | (32'h1 << $urandom_range(6, 31));
    return a;
  endfunction

  initial begin
    logic [1:0]    resp;
    logic [31:0]   d;
    logic [NR-1:0] pulse;
    logic          start;

    rst_n = 0;
    s_axi_awaddr = 0; s_axi_awprot = 0; s_axi_awvalid = 0;
    s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wvalid = 0;
    s_axi_bready = 0; s_axi_araddr = 0; s_axi_arprot = 0;
    s_axi_arvalid = 0; s_axi_rready = 0; hw_status = 0;
    model_reset();
    #1;
    compare();
    chk("rst_awready", RW'(s_axi_awready), RW'(1));
    chk("rst_reg_out", reg_out, RW'(0));
    cycle();
    cycle();
    rst_n = 1;
    cycle();

    // AW+W together, full word.
    do_write(32'h08, 32'hDEADBEEF, 4'hF, resp, pulse, start);
    chk("t1_bresp", RW'(resp), RW'(2'b00));
    chk("t1_pulse", RW'(pulse), RW'(16'h0004));
    do_read(32'h08, d, resp);
    chk("t1_rdata", RW'(d), RW'(32'hDEADBEEF));
    chk("t1_rresp", RW'(resp), RW'(2'b00));

    // W three cycles ahead of AW, low two byte lanes.
    s_axi_wdata = 32'h12345678; s_axi_wstrb = 4'h3; s_axi_wvalid = 1;
    s_axi_bready = 1;
    cycle();
    s_axi_wvalid = 0;
    chk("t2_wready_low", RW'(s_axi_wready), RW'(0));
    cycle();
    cycle();
    s_axi_awaddr = 32'h08; s_axi_awvalid = 1;
    cycle();
    s_axi_awvalid = 0;
    cycle();
    chk("t2_bvalid", RW'(s_axi_bvalid), RW'(1));
    cycle();
    s_axi_bready = 0;
    do_read(32'h08, d, resp);
    chk("t2_rdata", RW'(d), RW'(32'hDEAD5678));

    // Second write parked while the first B is stalled.
    s_axi_awaddr = 32'h10; s_axi_awvalid = 1;
    s_axi_wdata = 32'h11111111; s_axi_wstrb = 4'hF; s_axi_wvalid = 1;
    cycle();
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    cycle();
    chk("t3_b1", RW'(s_axi_bvalid), RW'(1));
    s_axi_awaddr = 32'h0C; s_axi_awvalid = 1;
    s_axi_wdata = 32'hCAFEF00D; s_axi_wvalid = 1;
    cycle();
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    chk("t3_awready", RW'(s_axi_awready), RW'(0));
    chk("t3_wready", RW'(s_axi_wready), RW'(0));
    repeat (3) cycle();
    chk("t3_b_held", RW'(s_axi_bvalid), RW'(1));
    chk("t3_reg3_old", RW'(reg_out[127:96]), RW'(0));
    s_axi_bready = 1;
    cycle();
    chk("t3_b_gap", RW'(s_axi_bvalid), RW'(0));
    cycle();
    chk("t3_b2", RW'(s_axi_bvalid), RW'(1));
    chk("t3_reg3", RW'(reg_out[127:96]), RW'(32'hCAFEF00D));
    chk("t3_pulse", RW'(wr_pulse), RW'(16'h0008));
    cycle();
    s_axi_bready = 0;

    // Out-of-range access.
    do_write(32'h40, 32'h55555555, 4'hF, resp, pulse, start);
    chk("t4_bresp", RW'(resp), RW'(2'b10));
    chk("t4_pulse", RW'(pulse), RW'(0));
    do_read(32'h40, d, resp);
    chk("t4_rdata", RW'(d), RW'(0));
    chk("t4_rresp", RW'(resp), RW'(2'b10));

    // CTRL start bit and STATUS.
    do_write(32'h00, 32'h00000003, 4'hF, resp, pulse, start);
    chk("t5_start", RW'(start), RW'(1));
    chk("t5_pulse", RW'(pulse), RW'(16'h0001));
    do_read(32'h00, d, resp);
    chk("t5_ctrl", RW'(d), RW'(32'h00000002));
    hw_status = 32'hA5;
    do_read(32'h04, d, resp);
    chk("t5_status", RW'(d), RW'(32'hA5));
    do_write(32'h04, 32'hFF, 4'hF, resp, pulse, start);
    chk("t5_st_bresp", RW'(resp), RW'(2'b00));
    chk("t5_st_pulse", RW'(pulse), RW'(0));
    do_read(32'h04, d, resp);
    chk("t5_status2", RW'(d), RW'(32'hA5));

    // Reset with both responses outstanding.
    s_axi_awaddr = 32'h14; s_axi_awvalid = 1;
    s_axi_wdata = 32'h0BADF00D; s_axi_wvalid = 1;
    s_axi_araddr = 32'h08; s_axi_arvalid = 1;
    cycle();
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
    cycle();
    chk("t6_bvalid", RW'(s_axi_bvalid), RW'(1));
    chk("t6_rvalid", RW'(s_axi_rvalid), RW'(1));
    rst_n = 0;
    #1;
    model_reset();
    compare();
    chk("t6_b_clr", RW'(s_axi_bvalid), RW'(0));
    chk("t6_r_clr", RW'(s_axi_rvalid), RW'(0));
    chk("t6_regs", reg_out, RW'(0));
    chk("t6_ready", RW'({s_axi_awready, s_axi_wready, s_axi_arready}), RW'(3'b111));
    @(negedge clk);
    cycle();
    rst_n = 1;
    cycle();

    // Random traffic; valids hold their payload until accepted.
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        rst_n = 0;
        #1;
        model_reset();
        compare();
      end
      if (n == 1503) rst_n = 1;
      if (!s_axi_awvalid || acc_aw) begin
        s_axi_awvalid = ($urandom_range(0, 2) != 0);
        s_axi_awaddr = rand_addr();
      end
      if (!s_axi_wvalid || acc_w) begin
        s_axi_wvalid = ($urandom_range(0, 2) != 0);
        s_axi_wdata = $urandom;
        s_axi_wstrb = 4'($urandom_range(0, 15));
      end
      if (!s_axi_arvalid || acc_ar) begin
        s_axi_arvalid = ($urandom_range(0, 2) != 0);
        s_axi_araddr = rand_addr();
      end
      s_axi_awprot = 3'($urandom_range(0, 7));
      s_axi_arprot = 3'($urandom_range(0, 7));
      s_axi_bready = ($urandom_range(0, 3) != 0);
      s_axi_rready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) hw_status = $urandom;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
